// File: rtl/data_link_pkg.sv
// Shared types and constants for the byte-level frame parser.
package data_link_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/frame_idle_timer.sv
// Counts consecutive idle cycles while a frame is open; expire is a combinational
// pulse on the TIMEOUT_CYC-th idle cycle. No backpressure.
module frame_idle_timer #(
  parameter int TIMEOUT_CYC = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic din_en,
  output logic expire
);

  // Only needs to reach TIMEOUT_CYC-1; the final idle cycle is detected, not counted.
  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] idle_cnt;

  assign expire = active && !din_en && (idle_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !active || din_en || expire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/byte_frame_parser.sv
// Sync/length/payload/checksum frame parser with saturating ok/err counters.
// All outputs registered, 1 cycle after the sampling edge; no backpressure.
module byte_frame_parser
  import data_link_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN     = 64,
  parameter int         TIMEOUT_CYC = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_en,
  output logic [7:0]  dout,
  output logic        dout_en,
  output logic        sof,
  output logic        eof,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state, state_nxt;
  logic [7:0] len, cnt, csum;
  logic       expire;
  logic       len_bad, last_byte;

  logic       dout_en_d, sof_d, eof_d, ok_d, err_d;
  logic [1:0] code_d;

  frame_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .active (state != HUNT),
    .din_en (din_en),
    .expire (expire)
  );

  assign len_bad   = (din == 8'd0) || (din > MAX_LEN_B);
  assign last_byte = (cnt == len - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (expire) begin
      state_nxt = HUNT;
    end else if (din_en) begin
      case (state)
        HUNT:    if (din == SYNC_BYTE) state_nxt = LEN;
        LEN:     state_nxt = len_bad ? HUNT : PAYLOAD;
        PAYLOAD: if (last_byte) state_nxt = CSUM;
        CSUM:    state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    dout_en_d = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = ERR_NONE;
    if (expire) begin
      err_d  = 1'b1;
      code_d = ERR_TIMEOUT;
    end else if (din_en) begin
      case (state)
        LEN: if (len_bad) begin
          err_d  = 1'b1;
          code_d = ERR_LEN;
        end
        PAYLOAD: begin
          dout_en_d = 1'b1;
          sof_d     = (cnt == 8'd0);
          eof_d     = last_byte;
        end
        CSUM: if (din == csum) begin
          ok_d = 1'b1;
        end else begin
          err_d  = 1'b1;
          code_d = ERR_CSUM;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      dout_en   <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      ok_cnt    <= '0;
      err_cnt   <= '0;
      len       <= '0;
      cnt       <= '0;
      csum      <= '0;
    end else begin
      dout_en   <= dout_en_d;
      sof       <= sof_d;
      eof       <= eof_d;
      frame_ok  <= ok_d;
      frame_err <= err_d;
      err_code  <= code_d;
      if (dout_en_d) dout <= din;
      if (ok_d && ok_cnt != 16'hFFFF)   ok_cnt  <= ok_cnt + 16'd1;
      if (err_d && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      // The length byte seeds the checksum; payload bytes accumulate mod 256.
      if (din_en && state == LEN && !len_bad) begin
        len  <= din;
        csum <= din;
        cnt  <= '0;
      end else if (din_en && state == PAYLOAD) begin
        csum <= csum + din;
        cnt  <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_byte_frame_parser.sv
// Directed bench for byte_frame_parser with hand-computed expectations.
module tb_byte_frame_parser;
  import data_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        din_en = 1'b0;
  logic [7:0]  dout;
  logic        dout_en, sof, eof, frame_ok, frame_err;
  logic [1:0]  err_code;
  logic [15:0] ok_cnt, err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  byte_frame_parser dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_en    (din_en),
    .dout      (dout),
    .dout_en   (dout_en),
    .sof       (sof),
    .eof       (eof),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .ok_cnt    (ok_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, sample #1 after the rising edge that consumes it.
  task automatic send(input logic [7:0] d, input logic en);
    @(negedge clk);
    din    = d;
    din_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pay(input string tag, input logic [7:0] d, input logic s, input logic e);
    chk({tag, "_en"},  {15'd0, dout_en}, 16'd1);
    chk({tag, "_dat"}, {8'd0, dout}, {8'd0, d});
    chk({tag, "_sof"}, {15'd0, sof}, {15'd0, s});
    chk({tag, "_eof"}, {15'd0, eof}, {15'd0, e});
  endtask

  task automatic chk_verdict(input string tag, input logic ok, input logic err, input logic [1:0] code);
    chk({tag, "_ok"},   {15'd0, frame_ok}, {15'd0, ok});
    chk({tag, "_err"},  {15'd0, frame_err}, {15'd0, err});
    chk({tag, "_code"}, {14'd0, err_code}, {14'd0, code});
    chk({tag, "_den"},  {15'd0, dout_en}, 16'd0);
  endtask

  initial begin
    // Reset state
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    rst = 1'b0;
    chk("rst_dout", {8'd0, dout}, 16'd0);
    chk_verdict("rst", 1'b0, 1'b0, ERR_NONE);
    chk("rst_ok_cnt", ok_cnt, 16'd0);
    chk("rst_err_cnt", err_cnt, 16'd0);

    // Good frame after junk bytes
    send(8'h00, 1'b1); chk("junk0_den", {15'd0, dout_en}, 16'd0);
    send(8'hFF, 1'b1); chk("junk1_den", {15'd0, dout_en}, 16'd0);
    send(8'hA5, 1'b1);
    send(8'h03, 1'b1); chk("len_den", {15'd0, dout_en}, 16'd0);
    send(8'h11, 1'b1); chk_pay("g_p0", 8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1); chk_pay("g_p1", 8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b1); chk_pay("g_p2", 8'h33, 1'b0, 1'b1);
    send(8'h69, 1'b1); chk_verdict("g_cs", 1'b1, 1'b0, ERR_NONE);
    chk("g_ok_cnt", ok_cnt, 16'd1);
    chk("g_err_cnt", err_cnt, 16'd0);
    send(8'h00, 1'b0); chk("g_ok_pulse", {15'd0, frame_ok}, 16'd0);

    // Checksum mismatch
    send(8'hA5, 1'b1);
    send(8'h03, 1'b1);
    send(8'h11, 1'b1); chk_pay("b_p0", 8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1); chk_pay("b_p1", 8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b1); chk_pay("b_p2", 8'h33, 1'b0, 1'b1);
    send(8'h68, 1'b1); chk_verdict("b_cs", 1'b0, 1'b1, ERR_CSUM);
    chk("b_err_cnt", err_cnt, 16'd1);
    chk("b_ok_cnt", ok_cnt, 16'd1);

    // Bad lengths: zero and above MAX_LEN
    send(8'hA5, 1'b1);
    send(8'h00, 1'b1); chk_verdict("len0", 1'b0, 1'b1, ERR_LEN);
    chk("len0_err_cnt", err_cnt, 16'd2);
    send(8'hA5, 1'b1);
    send(8'h41, 1'b1); chk_verdict("len65", 1'b0, 1'b1, ERR_LEN);
    chk("len65_err_cnt", err_cnt, 16'd3);
    send(8'h10, 1'b1); chk("len65_hunt_den", {15'd0, dout_en}, 16'd0);

    // Timeout after exactly 32 idle cycles
    send(8'hA5, 1'b1);
    send(8'h02, 1'b1);
    send(8'h10, 1'b1); chk_pay("to_p0", 8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 31; i++) send(8'h00, 1'b0);
    chk("to_31_err", {15'd0, frame_err}, 16'd0);
    send(8'h00, 1'b0); chk_verdict("to_32", 1'b0, 1'b1, ERR_TIMEOUT);
    chk("to_err_cnt", err_cnt, 16'd4);

    // 31-cycle gap survives
    send(8'hA5, 1'b1);
    send(8'h02, 1'b1);
    send(8'h10, 1'b1); chk_pay("gap_p0", 8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 31; i++) send(8'h00, 1'b0);
    chk("gap_31_err", {15'd0, frame_err}, 16'd0);
    send(8'h20, 1'b1); chk_pay("gap_p1", 8'h20, 1'b0, 1'b1);
    send(8'h32, 1'b1); chk_verdict("gap_cs", 1'b1, 1'b0, ERR_NONE);
    chk("gap_ok_cnt", ok_cnt, 16'd2);

    // Back-to-back frames, sync byte as payload data
    send(8'hA5, 1'b1);
    send(8'h01, 1'b1);
    send(8'hA5, 1'b1); chk_pay("bb1_p0", 8'hA5, 1'b1, 1'b1);
    send(8'hA6, 1'b1); chk_verdict("bb1_cs", 1'b1, 1'b0, ERR_NONE);
    send(8'hA5, 1'b1); chk("bb2_sync_ok", {15'd0, frame_ok}, 16'd0);
    send(8'h01, 1'b1);
    send(8'h7E, 1'b1); chk_pay("bb2_p0", 8'h7E, 1'b1, 1'b1);
    send(8'h7F, 1'b1); chk_verdict("bb2_cs", 1'b1, 1'b0, ERR_NONE);
    chk("bb_ok_cnt", ok_cnt, 16'd4);
    chk("bb_err_cnt", err_cnt, 16'd4);

    // Reset mid-payload
    send(8'hA5, 1'b1);
    send(8'h03, 1'b1);
    send(8'h11, 1'b1); chk_pay("mr_p0", 8'h11, 1'b1, 1'b0);
    rst = 1'b1;
    send(8'h22, 1'b1);
    rst = 1'b0;
    chk("mr_dout", {8'd0, dout}, 16'd0);
    chk("mr_sof", {15'd0, sof}, 16'd0);
    chk_verdict("mr", 1'b0, 1'b0, ERR_NONE);
    chk("mr_ok_cnt", ok_cnt, 16'd0);
    chk("mr_err_cnt", err_cnt, 16'd0);
    send(8'hA5, 1'b1);
    send(8'h01, 1'b1);
    send(8'h7E, 1'b1); chk_pay("mr2_p0", 8'h7E, 1'b1, 1'b1);
    send(8'h7F, 1'b1); chk_verdict("mr2_cs", 1'b1, 1'b0, ERR_NONE);
    chk("mr2_ok_cnt", ok_cnt, 16'd1);
    chk("mr2_err_cnt", err_cnt, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
